// File: rtl/intra_ram_pp_dp_pkg.sv
// Shared defaults, handshake state and next-state rule for the intra ping-pong buffer.
`ifndef INTRA_RAM_PP_WORD_WIDTH
`define INTRA_RAM_PP_WORD_WIDTH 32
`endif
`ifndef INTRA_RAM_PP_ADDR_WIDTH
`define INTRA_RAM_PP_ADDR_WIDTH 6
`endif

package intra_ram_pp_dp_pkg;

   localparam int unsigned DEF_WORD_WIDTH = `INTRA_RAM_PP_WORD_WIDTH;
   localparam int unsigned DEF_ADDR_WIDTH = `INTRA_RAM_PP_ADDR_WIDTH;

   typedef struct packed {
      logic [1:0] full;
      logic       wr_bank;
      logic       rd_bank;
   } pp_ctrl_t;

   localparam pp_ctrl_t PP_CTRL_RST = '{full: 2'b00, wr_bank: 1'b0, rd_bank: 1'b0};

   // A ready write bank is empty and a ready read bank is full, so both
   // releases always touch different banks and can be applied together.
   function automatic pp_ctrl_t pp_next(input pp_ctrl_t cur, input logic wr_done,
                                        input logic rd_done);
      pp_ctrl_t nxt;
      nxt = cur;
      if (wr_done && !cur.full[cur.wr_bank]) begin
         nxt.full[cur.wr_bank] = 1'b1;
         nxt.wr_bank           = ~cur.wr_bank;
      end
      if (rd_done && cur.full[cur.rd_bank]) begin
         nxt.full[cur.rd_bank] = 1'b0;
         nxt.rd_bank           = ~cur.rd_bank;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/intra_ram_pp_bank.sv
// Single-clock byte-enabled RAM bank: one write port, one registered read port.
module intra_ram_pp_bank #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addrw_i,
   input  logic [WORD_WIDTH-1:0]   dataw_i,
   input  logic [WORD_WIDTH/8-1:0] be_i,
   input  logic                    re_i,
   input  logic [ADDR_WIDTH-1:0]   addrr_i,
   output logic [WORD_WIDTH-1:0]   datar_o
);

   localparam int unsigned NBYTES = WORD_WIDTH / 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

   logic [WORD_WIDTH-1:0] mem_q [DEPTH];
   logic [WORD_WIDTH-1:0] rdata_q;

   // Storage array carries no reset so it maps onto a RAM macro.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (be_i[k]) mem_q[addrw_i][8*k +: 8] <= dataw_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[addrr_i];
   end

   assign datar_o = rdata_q;

endmodule

// File: rtl/intra_ram_pp_dp.sv
// Ping-pong dual-port buffer for intra reference pixels with full/empty bank handover.
// Optional output register stage: define INTRA_RAM_PP_OREG_EN.
module intra_ram_pp_dp
   import intra_ram_pp_dp_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cena_i,
   input  logic                    wena_i,
   input  logic [ADDR_WIDTH-1:0]   addra_i,
   input  logic [WORD_WIDTH-1:0]   dataa_i,
   input  logic [WORD_WIDTH/8-1:0] bea_i,
   input  logic                    wr_done_i,
   output logic                    wr_rdy_o,
   output logic                    wr_bank_o,
   input  logic                    cenb_i,
   input  logic [ADDR_WIDTH-1:0]   addrb_i,
   output logic [WORD_WIDTH-1:0]   datab_o,
   output logic                    validb_o,
   input  logic                    rd_done_i,
   output logic                    rd_rdy_o,
   output logic                    rd_bank_o
);

   pp_ctrl_t              ctrl_q, ctrl_d;
   logic                  wr_rdy, rd_rdy, wr_acc, rd_acc;
   logic [1:0]            bank_we, bank_re;
   logic [WORD_WIDTH-1:0] bank_rdata [2];
   logic                  rsel_q;
   logic                  rvalid_q;
   logic [WORD_WIDTH-1:0] rd_word;

   assign wr_rdy = ~ctrl_q.full[ctrl_q.wr_bank];
   assign rd_rdy = ctrl_q.full[ctrl_q.rd_bank];
   assign wr_acc = ~cena_i & ~wena_i & wr_rdy;
   assign rd_acc = ~cenb_i & rd_rdy;

   always_comb begin
      ctrl_d = ctrl_q;
      ctrl_d = pp_next(ctrl_q, wr_done_i, rd_done_i);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ctrl_q <= PP_CTRL_RST;
      else       ctrl_q <= ctrl_d;
   end

   assign bank_we = {wr_acc & ctrl_q.wr_bank, wr_acc & ~ctrl_q.wr_bank};
   assign bank_re = {rd_acc & ctrl_q.rd_bank, rd_acc & ~ctrl_q.rd_bank};

   for (genvar b = 0; b < 2; b++) begin : g_bank
      intra_ram_pp_bank #(
         .WORD_WIDTH (WORD_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
         .clk     (clk),
         .rstn    (rstn),
         .we_i    (bank_we[b]),
         .addrw_i (addra_i),
         .dataw_i (dataa_i),
         .be_i    (bea_i),
         .re_i    (bank_re[b]),
         .addrr_i (addrb_i),
         .datar_o (bank_rdata[b])
      );
   end

   // Bank select only moves on an accepted read, so the mux output holds otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsel_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_acc;
         if (rd_acc) rsel_q <= ctrl_q.rd_bank;
      end
   end

   assign rd_word = rsel_q ? bank_rdata[1] : bank_rdata[0];

`ifdef INTRA_RAM_PP_OREG_EN
   logic [WORD_WIDTH-1:0] oreg_q;
   logic                  ovalid_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oreg_q   <= '0;
         ovalid_q <= 1'b0;
      end else begin
         ovalid_q <= rvalid_q;
         if (rvalid_q) oreg_q <= rd_word;
      end
   end

   assign datab_o  = oreg_q;
   assign validb_o = ovalid_q;
`else
   assign datab_o  = rd_word;
   assign validb_o = rvalid_q;
`endif

   assign wr_rdy_o  = wr_rdy;
   assign rd_rdy_o  = rd_rdy;
   assign wr_bank_o = ctrl_q.wr_bank;
   assign rd_bank_o = ctrl_q.rd_bank;

endmodule

// File: tb/tb_intra_ram_pp_dp.sv
// Scoreboard bench for intra_ram_pp_dp: bank handover, byte enables, drops, reset.
module tb_intra_ram_pp_dp;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cena, wena, wr_done, cenb, rd_done;
   logic [5:0]  addra, addrb;
   logic [31:0] dataa;
   logic [3:0]  bea;
   logic        wr_rdy, wr_bank, rd_rdy, rd_bank, validb;
   logic [31:0] datab;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [2][64];
   bit          m_full [2];
   bit          m_wb, m_rb;
   logic [31:0] sb_q [$];
   logic [31:0] exp_d, last_d;

   always #5 clk = ~clk;

   intra_ram_pp_dp dut (
      .clk(clk), .rstn(rstn),
      .cena_i(cena), .wena_i(wena), .addra_i(addra), .dataa_i(dataa), .bea_i(bea),
      .wr_done_i(wr_done), .wr_rdy_o(wr_rdy), .wr_bank_o(wr_bank),
      .cenb_i(cenb), .addrb_i(addrb), .datab_o(datab), .validb_o(validb),
      .rd_done_i(rd_done), .rd_rdy_o(rd_rdy), .rd_bank_o(rd_bank)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_full[0] = 1'b0; m_full[1] = 1'b0; m_wb = 1'b0; m_rb = 1'b0;
   endtask

   // Sets up a write for the coming edge and updates the model if it will be accepted.
   task automatic set_write(input int a, input logic [31:0] d, input logic [3:0] be);
      cena = 1'b0; wena = 1'b0; addra = 6'(a); dataa = d; bea = be;
      if (!m_full[m_wb])
         for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[m_wb][a][8*k +: 8] = d[8*k +: 8];
   endtask

   task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
      set_write(a, d, be);
      cyc();
      cena = 1'b1; wena = 1'b1;
   endtask

   task automatic issue_read(input int a);
      cenb = 1'b0; addrb = 6'(a);
      if (m_full[m_rb]) sb_q.push_back(ref_mem[m_rb][a]);
   endtask

   task automatic model_done(input bit wd, input bit rd);
      bit wr_ok, rd_ok;
      wr_ok = wd && !m_full[m_wb];
      rd_ok = rd && m_full[m_rb];
      if (wr_ok) begin m_full[m_wb] = 1'b1; m_wb = ~m_wb; end
      if (rd_ok) begin m_full[m_rb] = 1'b0; m_rb = ~m_rb; end
   endtask

   task automatic pulse_done(input bit wd, input bit rd);
      wr_done = wd; rd_done = rd;
      model_done(wd, rd);
      cyc();
      wr_done = 1'b0; rd_done = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      cena = 1'b1; wena = 1'b1; cenb = 1'b1; wr_done = 1'b0; rd_done = 1'b0;
      addra = '0; addrb = '0; dataa = '0; bea = '0;
      model_reset();
      last_d = '0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      cyc();
      checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_wr_rdy: got %b expected 1", wr_rdy); end
      checks++; if (rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rd_rdy: got %b expected 0", rd_rdy); end
      checks++; if (validb !== 1'b0) begin errors++; $display("FAIL reset_validb: got %b expected 0", validb); end
      checks++; if (datab !== 32'h0) begin errors++; $display("FAIL reset_datab: got %h expected 0", datab); end
      checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin errors++; $display("FAIL reset_banks: got wr=%b rd=%b expected 0 0", wr_bank, rd_bank); end
   endtask

   task automatic test_fill_read();
      for (int a = 0; a < 64; a++) do_write(a, 32'(a), 4'hF);
      pulse_done(1'b1, 1'b0);
      checks++; if (rd_rdy !== 1'b1 || rd_bank !== 1'b0) begin errors++; $display("FAIL fill_rd_rdy: got rdy=%b bank=%b expected 1 0", rd_rdy, rd_bank); end
      checks++; if (wr_rdy !== 1'b1 || wr_bank !== 1'b1) begin errors++; $display("FAIL fill_wr_side: got rdy=%b bank=%b expected 1 1", wr_rdy, wr_bank); end
      issue_read(5);
      cyc();
      cenb = 1'b1;
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
      checks++; if (validb !== 1'b1 || datab !== exp_d || exp_d !== 32'h5) begin errors++; $display("FAIL read_addr5: got valid=%b data=%h expected 1 %h", validb, datab, exp_d); end
      last_d = exp_d;
      cyc();
      checks++; if (validb !== 1'b0 || datab !== last_d) begin errors++; $display("FAIL read_idle_hold: got valid=%b data=%h expected 0 %h", validb, datab, last_d); end
   endtask

   task automatic test_byte_enable();
      do_write(10, 32'hAABBCCDD, 4'hF);
      do_write(10, 32'h11223344, 4'b0101);
      pulse_done(1'b1, 1'b0);
      checks++; if (wr_rdy !== 1'b0 || rd_rdy !== 1'b1) begin errors++; $display("FAIL both_full: got wr_rdy=%b rd_rdy=%b expected 0 1", wr_rdy, rd_rdy); end
      do_write(3, 32'hDEADBEEF, 4'hF);
      pulse_done(1'b1, 1'b0);
      checks++; if (wr_bank !== m_wb || wr_rdy !== 1'b0) begin errors++; $display("FAIL wr_done_ignored: got bank=%b rdy=%b expected %b 0", wr_bank, wr_rdy, m_wb); end
      pulse_done(1'b0, 1'b1);
      checks++; if (wr_rdy !== 1'b1 || wr_bank !== 1'b0) begin errors++; $display("FAIL release_wr: got rdy=%b bank=%b expected 1 0", wr_rdy, wr_bank); end
      checks++; if (rd_rdy !== 1'b1 || rd_bank !== 1'b1) begin errors++; $display("FAIL release_rd: got rdy=%b bank=%b expected 1 1", rd_rdy, rd_bank); end
      issue_read(10);
      cyc();
      cenb = 1'b1;
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
      checks++; if (validb !== 1'b1 || datab !== exp_d || exp_d !== 32'hAA22CC44) begin errors++; $display("FAIL byte_enable: got valid=%b data=%h expected 1 %h", validb, datab, exp_d); end
      last_d = exp_d;
      pulse_done(1'b0, 1'b1);
      checks++; if (rd_rdy !== 1'b0 || wr_rdy !== 1'b1) begin errors++; $display("FAIL both_empty: got rd_rdy=%b wr_rdy=%b expected 0 1", rd_rdy, wr_rdy); end
   endtask

   task automatic test_back_to_back();
      int addrs [4] = '{3, 20, 63, 0};
      int budget;
      do_write(20, 32'h0000_0055, 4'hF);
      pulse_done(1'b1, 1'b0);
      foreach (addrs[i]) begin
         issue_read(addrs[i]);
         cyc();
         if (validb === 1'b1) begin
            exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
            checks++; if (datab !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, datab, exp_d); end
            last_d = exp_d;
         end
      end
      cenb = 1'b1;
      budget = 4;
      while (sb_q.size() > 0 && budget > 0) begin
         cyc();
         budget--;
         if (validb === 1'b1) begin
            exp_d = sb_q.pop_front();
            checks++; if (datab !== exp_d) begin errors++; $display("FAIL b2b_drain: got %h expected %h", datab, exp_d); end
            last_d = exp_d;
         end
      end
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_timeout: got %0d pending expected 0", sb_q.size()); sb_q.delete(); end
   endtask

   task automatic test_simul_done();
      issue_read(20);
      set_write(7, 32'h0000_0077, 4'hF);
      wr_done = 1'b1; rd_done = 1'b1;
      model_done(1'b1, 1'b1);
      cyc();
      wr_done = 1'b0; rd_done = 1'b0; cena = 1'b1; wena = 1'b1; cenb = 1'b1;
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
      checks++; if (validb !== 1'b1 || datab !== exp_d || exp_d !== 32'h55) begin errors++; $display("FAIL read_old_bank: got valid=%b data=%h expected 1 %h", validb, datab, exp_d); end
      checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin errors++; $display("FAIL simul_banks: got wr=%b rd=%b expected 0 1", wr_bank, rd_bank); end
      checks++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b1) begin errors++; $display("FAIL simul_rdy: got wr=%b rd=%b expected 1 1", wr_rdy, rd_rdy); end
      issue_read(7);
      cyc();
      cenb = 1'b1;
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
      checks++; if (validb !== 1'b1 || datab !== exp_d || exp_d !== 32'h77) begin errors++; $display("FAIL write_old_bank: got valid=%b data=%h expected 1 %h", validb, datab, exp_d); end
      last_d = exp_d;
   endtask

   task automatic test_reset_mid();
      pulse_done(1'b0, 1'b1);
      issue_read(4);
      cyc();
      cenb = 1'b1;
      checks++; if (validb !== 1'b0 || datab !== last_d || sb_q.size() != 0) begin errors++; $display("FAIL dropped_read: got valid=%b data=%h expected 0 %h", validb, datab, last_d); end
      do_write(1, 32'h0000_1234, 4'hF);
      pulse_done(1'b1, 1'b0);
      checks++; if (rd_rdy !== 1'b1 || wr_bank !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got rd_rdy=%b wr_bank=%b expected 1 1", rd_rdy, wr_bank); end
      issue_read(1);
      #3 rstn = 1'b0;
      #1;
      checks++; if (wr_bank !== 1'b0 || rd_rdy !== 1'b0) begin errors++; $display("FAIL async_reset: got wr_bank=%b rd_rdy=%b expected 0 0", wr_bank, rd_rdy); end
      cyc();
      checks++; if (validb !== 1'b0 || datab !== 32'h0) begin errors++; $display("FAIL reset_mid_read: got valid=%b data=%h expected 0 0", validb, datab); end
      cenb = 1'b1;
      sb_q.delete();
      model_reset();
      rstn = 1'b1;
      cyc();
      checks++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0 || validb !== 1'b0 || datab !== 32'h0 || wr_bank !== 1'b0 || rd_bank !== 1'b0)
         begin errors++; $display("FAIL post_reset: got wr_rdy=%b rd_rdy=%b valid=%b data=%h wb=%b rb=%b expected 1 0 0 0 0 0", wr_rdy, rd_rdy, validb, datab, wr_bank, rd_bank); end
   endtask

   initial begin
      test_reset();
      test_fill_read();
      test_byte_enable();
      test_back_to_back();
      test_simul_done();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/intra_ram_pp_dp.md
# intra_ram_pp_dp

Parametrised ping-pong dual-port buffer for intra reference pixels. Two banks of `2^ADDR_WIDTH` words each. Port A (producer, the neighbour-pixel fetch) fills one bank while port B (consumer, the prediction engine) reads the other. Bank ownership is tracked by a full/empty handshake, and byte-enabled writes support partial-pixel updates.

## Interface
Parameters:
- WORD_WIDTH, 32, data word width; must be a multiple of 8
- ADDR_WIDTH, 6, address width per bank; depth = 2^ADDR_WIDTH

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- cena_i  in  1  port A access enable, active-low
- wena_i  in  1  port A write enable, active-low; a write requires cena_i=0 and wena_i=0
- addra_i  in  ADDR_WIDTH  port A address in the current write bank
- dataa_i  in  WORD_WIDTH  port A write data
- bea_i  in  WORD_WIDTH/8  byte enables, active-high; bit k covers dataa_i[8k+7:8k]
- wr_done_i  in  1  single-cycle pulse: producer releases the write bank as full
- wr_rdy_o  out  1  a write bank is available (it is empty)
- wr_bank_o  out  1  index of the current write bank
- cenb_i  in  1  port B read enable, active-low
- addrb_i  in  ADDR_WIDTH  port B address in the current read bank
- datab_o  out  WORD_WIDTH  read data
- validb_o  out  1  datab_o carries data from an accepted read
- rd_done_i  in  1  single-cycle pulse: consumer releases the read bank as empty
- rd_rdy_o  out  1  a full bank is available for reading
- rd_bank_o  out  1  index of the current read bank

## Operation
- Each bank has a `full` state flag. `wr_bank` and `rd_bank` are 1-bit pointers. All three are registers.
- wr_rdy_o = !full[wr_bank]; rd_rdy_o = full[rd_bank]. Both are decoded from registers, with no input-to-output combinational path.
- Write accepted: cena_i=0, wena_i=0 and wr_rdy_o=1. Bytes with bea_i[k]=1 are written to mem[wr_bank][addra_i]. If wr_rdy_o=0, the write is dropped.
- Read accepted: cenb_i=0 and rd_rdy_o=1. If rd_rdy_o=0, the read is dropped, validb_o=0, and datab_o holds its value.
- wr_done_i with wr_rdy_o=1: full[wr_bank] is set to 1 and wr_bank toggles. If wr_rdy_o=0, wr_done_i is ignored.
- rd_done_i with rd_rdy_o=1: full[rd_bank] is cleared to 0 and rd_bank toggles. If rd_rdy_o=0, rd_done_i is ignored.
- Simultaneous wr_done_i and rd_done_i: both are honoured in the same cycle.
- Write together with wr_done_i in the same cycle: the write lands in the old bank, then the pointer toggles.
- Read together with rd_done_i in the same cycle: the read is served from the old bank.
- Port A and port B never address the same bank at the same time, so no read/write collision logic is needed.
- Both banks full: wr_rdy_o=0 and the producer stalls. Both banks empty: rd_rdy_o=0.
- Bank contents are not cleared by reset.

## Timing
- Reset values: datab_o=0, validb_o=0, wr_rdy_o=1, rd_rdy_o=0, wr_bank_o=0, rd_bank_o=0, full=2'b00.
- Read latency is 1 cycle: a read accepted at edge n gives datab_o and validb_o=1 after edge n. validb_o is 0 in any cycle without an accepted read.
- Handover latency: wr_done_i sampled at edge n makes rd_rdy_o=1 after edge n (when that bank is the read bank). The earliest read data is then available after edge n+1.
- Reset mid-operation: all flags and pointers return to their reset values immediately (asynchronously). Any in-flight read is discarded.

## Configuration
- INTRA_RAM_PP_OREG_EN defined: an extra output register is added after the RAM. Read latency becomes 2 cycles and validb_o is delayed to match. Both pipeline stages reset to 0.
- INTRA_RAM_PP_OREG_EN undefined: read latency is 1 cycle, as described under Timing.
- Handshake timing is the same in both cases.

## Structure
- The default WORD_WIDTH and ADDR_WIDTH values are defined in enc_defines.v as `INTRA_RAM_PP_WORD_WIDTH` and `INTRA_RAM_PP_ADDR_WIDTH`.
- Sub-module intra_ram_pp_bank: a single-clock byte-enabled synchronous RAM with one write port and one registered read port. It is instantiated twice.
- The top level holds the full flags, the bank pointers, the read-data mux and the optional output register.

## Test plan
- Reset → wr_rdy_o=1, rd_rdy_o=0, validb_o=0, datab_o=0, both bank outputs 0.
- Write addr 0..63 with data=addr and bea=4'hF, then pulse wr_done → next cycle rd_rdy_o=1 and rd_bank_o=0. Reading addr 5 returns 0x00000005 with validb_o=1 one cycle later.
- Write 0xAABBCCDD, then 0x11223344 with bea=4'b0101 to the same address → the read returns 0xAA22CC44.
- Fill both banks (two wr_done pulses) → wr_rdy_o=0 and a further write is dropped. Pulse rd_done → wr_rdy_o=1 and wr_bank_o=0.
- With bank 1 in write and bank 0 readable, pulse wr_done and rd_done in the same cycle → full=2'b10, wr_bank_o=0, rd_bank_o=1, wr_rdy_o=1, rd_rdy_o=1.
- Read with rd_rdy_o=0, and read then assert rstn=0 mid-read → validb_o stays 0 in both cases. After release, outputs equal the reset values.
